// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared FSM encoding and arithmetic helpers for the systolic GEMM
// Rev 1.0
// ============================================================================
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Wide enough to hold any accumulator (up to 128 bits) plus one carry bit.
  localparam int SAT_W = 130;

  // Index width that never collapses to zero bits when the count is 1.
  function automatic int row_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] acc,
    input logic signed [SAT_W-1:0] prod,
    input int                      width
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = acc + prod;
    hi  = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
    lo  = -hi - SAT_W'(1);
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe.sv
`default_nettype none
// ============================================================================
// systolic_pe : one output-stationary signed MAC cell; a flows right, w flows down
// Optional: SYSTOLIC_SAT_EN (saturating accumulate, sat strobe). Rev 1.0
// ============================================================================
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] a_in,
  input  logic signed [DATA_WIDTH-1:0] w_in,
  output logic signed [DATA_WIDTH-1:0] a_out,
  output logic signed [DATA_WIDTH-1:0] w_out,
  output logic signed [ACC_WIDTH-1:0]  acc
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                         sat
`endif
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_next;

  assign prod = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(w_in);

`ifdef SYSTOLIC_SAT_EN
  logic signed [SAT_W-1:0] sum_raw;
  logic signed [SAT_W-1:0] sum_clamped;
  assign sum_raw     = SAT_W'(acc) + SAT_W'(prod);
  assign sum_clamped = sat_add(SAT_W'(acc), SAT_W'(prod), ACC_WIDTH);
  assign acc_next    = sum_clamped[ACC_WIDTH-1:0];
  assign sat         = en && (sum_clamped != sum_raw);
`else
  assign acc_next = acc + ACC_WIDTH'(prod);
`endif

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      a_out <= '0;
      w_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      w_out <= w_in;
      acc   <= acc_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_gemm_stream.sv
`default_nettype none
// ============================================================================
// systolic_gemm_stream : MxM output-stationary GEMM, valid/ready operand lanes, row-serial results
// Optional: SYSTOLIC_SAT_EN (saturating accumulators + sticky sat_flag). Rev 1.0
// ============================================================================
module systolic_gemm_stream
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int M          = 4,
  parameter int K_MAX      = 256,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [KW-1:0]                k_len,
  output logic                         busy,
  input  logic [M-1:0]                 s_valid_a,
  output logic [M-1:0]                 s_ready_a,
  input  logic signed [DATA_WIDTH-1:0] s_data_a [M],
  input  logic [M-1:0]                 s_valid_w,
  output logic [M-1:0]                 s_ready_w,
  input  logic signed [DATA_WIDTH-1:0] s_data_w [M],
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [ACC_WIDTH-1:0]  m_data [M],
  output logic [row_width(M)-1:0]      m_row,
  output logic                         m_last,
  output logic                         done
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                         sat_flag
`endif
);

  localparam int RW = row_width(M);
  localparam int FW = row_width(2 * M);

  state_e        state;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row;

  logic all_valid;
  logic beat;
  logic arr_en;
  logic start_ok;

  assign all_valid = &{s_valid_a, s_valid_w};
  assign beat      = (state == FEED) && all_valid;
  assign arr_en    = beat || (state == FLUSH);
  assign start_ok  = (state == IDLE) && start && (k_len != '0) && (k_len <= KW'(K_MAX));

  assign s_ready_a = {M{beat}};
  assign s_ready_w = {M{beat}};
  assign busy      = (state != IDLE);
  assign m_valid   = (state == DRAIN);
  assign m_row     = row;
  assign m_last    = (state == DRAIN) && (row == RW'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            k_reg    <= k_len;
            beat_cnt <= '0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (beat) begin
            if (beat_cnt == k_reg - KW'(1)) begin
              flush_cnt <= '0;
              state     <= FLUSH;
            end else begin
              beat_cnt <= beat_cnt + KW'(1);
            end
          end
        end
        // 2M-1 zero cycles push the last beat through the far corner PE.
        FLUSH: begin
          if (flush_cnt == FW'(2 * M - 2)) begin
            row   <= '0;
            state <= DRAIN;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (row == RW'(M - 1)) begin
              row   <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              row <= row + RW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic signed [DATA_WIDTH-1:0] a_src  [M];
  logic signed [DATA_WIDTH-1:0] w_src  [M];
  logic signed [DATA_WIDTH-1:0] a_edge [M];
  logic signed [DATA_WIDTH-1:0] w_edge [M];

  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_src[i] = (state == FEED) ? s_data_a[i] : '0;
      w_src[i] = (state == FEED) ? s_data_w[i] : '0;
    end
  end

  // Lane i enters the array i enabled cycles late so operands meet on diagonals.
  for (genvar i = 0; i < M; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_src[i];
      assign w_edge[i] = w_src[i];
    end else begin : g_delay
      logic signed [DATA_WIDTH-1:0] a_pipe [i];
      logic signed [DATA_WIDTH-1:0] w_pipe [i];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int d = 0; d < i; d++) begin
            a_pipe[d] <= '0;
            w_pipe[d] <= '0;
          end
        end else if (arr_en) begin
          a_pipe[0] <= a_src[i];
          w_pipe[0] <= w_src[i];
          for (int d = 1; d < i; d++) begin
            a_pipe[d] <= a_pipe[d-1];
            w_pipe[d] <= w_pipe[d-1];
          end
        end
      end
      assign a_edge[i] = a_pipe[i-1];
      assign w_edge[i] = w_pipe[i-1];
    end
  end

  logic signed [DATA_WIDTH-1:0] a_h [M][M+1];
  logic signed [DATA_WIDTH-1:0] w_v [M+1][M];
  logic signed [ACC_WIDTH-1:0]  acc [M][M];
`ifdef SYSTOLIC_SAT_EN
  logic [M*M-1:0] sat_vec;
`endif

  for (genvar i = 0; i < M; i++) begin : g_row
    assign a_h[i][0] = a_edge[i];
    assign w_v[0][i] = w_edge[i];
    for (genvar j = 0; j < M; j++) begin : g_col
      systolic_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk  (clk),
        .reset(reset),
        .en   (arr_en),
        .clr  (start_ok),
        .a_in (a_h[i][j]),
        .w_in (w_v[i][j]),
        .a_out(a_h[i][j+1]),
        .w_out(w_v[i+1][j]),
        .acc  (acc[i][j])
`ifdef SYSTOLIC_SAT_EN
        ,
        .sat  (sat_vec[i*M+j])
`endif
      );
    end
  end

  // Operands falling off the right and bottom edges are intentionally dropped.
  logic unused_edge;
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < M; i++) begin
      unused_edge = unused_edge ^ (^a_h[i][M]) ^ (^w_v[M][i]);
    end
  end

  always_comb begin
    for (int j = 0; j < M; j++) begin
      m_data[j] = acc[row][j];
    end
  end

`ifdef SYSTOLIC_SAT_EN
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      sat_flag <= 1'b0;
    end else if (|sat_vec) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_systolic_gemm_stream.sv
`default_nettype none
// ============================================================================
// tb_systolic_gemm_stream : directed table plus randomized jobs against a matrix-product model
// Rev 1.0
// ============================================================================
module tb_systolic_gemm_stream;

  localparam int M     = 3;
  localparam int DW    = 16;
  localparam int AW    = 32;
  localparam int K_MAX = 8;
  localparam int KW    = $clog2(K_MAX + 1);
  localparam int RW    = $clog2(M);
  localparam int NV    = 7;

  typedef struct packed {
    logic [3:0]                     k;
    logic [3:0]                     gap_at;
    logic [3:0]                     gap_len;
    logic [1:0]                     hold_row;
    logic [3:0]                     hold_len;
    logic [7:0][M-1:0][DW-1:0]      a;    // a[beat][row lane]  = A[row][beat]
    logic [7:0][M-1:0][DW-1:0]      w;    // w[beat][col lane]  = W[beat][col]
    logic [M-1:0][M-1:0][AW-1:0]    c;    // expected C[row][col]
    logic                           sat;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 busy;
  logic [M-1:0]         s_valid_a;
  logic [M-1:0]         s_ready_a;
  logic signed [DW-1:0] s_data_a [M];
  logic [M-1:0]         s_valid_w;
  logic [M-1:0]         s_ready_w;
  logic signed [DW-1:0] s_data_w [M];
  logic                 m_valid;
  logic                 m_ready;
  logic signed [AW-1:0] m_data [M];
  logic [RW-1:0]        m_row;
  logic                 m_last;
  logic                 done;
`ifdef SYSTOLIC_SAT_EN
  logic                 sat_flag;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  systolic_gemm_stream #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .M         (M),
    .K_MAX     (K_MAX),
    .KW        (KW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .k_len    (k_len),
    .busy     (busy),
    .s_valid_a(s_valid_a),
    .s_ready_a(s_ready_a),
    .s_data_a (s_data_a),
    .s_valid_w(s_valid_w),
    .s_ready_w(s_ready_w),
    .s_data_w (s_data_w),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_row    (m_row),
    .m_last   (m_last),
    .done     (done)
`ifdef SYSTOLIC_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Plain matrix product; saturation (when built in) clamps after every k step.
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    longint s, mx, mn;
    mx = (longint'(1) <<< (AW - 1)) - 1;
    mn = -mx - 1;
    r.sat = 1'b0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        s = 0;
        for (int kk = 0; kk < int'(v.k); kk++) begin
          s += longint'($signed(v.a[kk][i])) * longint'($signed(v.w[kk][j]));
`ifdef SYSTOLIC_SAT_EN
          if (s > mx) begin s = mx; r.sat = 1'b1; end
          else if (s < mn) begin s = mn; r.sat = 1'b1; end
`endif
        end
        r.c[i][j] = s[AW-1:0];
      end
    end
    return r;
  endfunction

  task automatic set_row(input int t, input int r, input int x0, input int x1, input int x2);
    vecs[t].c[r] = {AW'(x2), AW'(x1), AW'(x0)};
  endtask

  // Entered and left on a negedge, so consecutive calls start in the done cycle.
  task automatic run_job(input vec_t v, input string tag);
    int                   t0, first_mv, done_c, beat, gap_left, held, nrow, budget;
    bit                   all_v;
    logic signed [AW-1:0] got [M][M];
    logic signed [AW-1:0] snap [M];
    logic [RW-1:0]        snap_row;
    for (int i = 0; i < M; i++) for (int j = 0; j < M; j++) got[i][j] = '0;
    for (int j = 0; j < M; j++) snap[j] = '0;
    snap_row = '0;
    start = 1'b1;
    k_len = KW'(v.k);
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, 1);
    beat = 0; gap_left = int'(v.gap_len); budget = 0;
    while (beat < int'(v.k) && budget < 40) begin
      for (int i = 0; i < M; i++) begin
        s_data_a[i] = $signed(v.a[beat][i]);
        s_data_w[i] = $signed(v.w[beat][i]);
      end
      s_valid_a = '1;
      s_valid_w = '1;
      if (beat == int'(v.gap_at) && gap_left > 0) begin
        s_valid_w[1] = 1'b0;
        gap_left--;
      end
      all_v = &{s_valid_a, s_valid_w};
      #1;
      check({tag, " s_ready_a"}, s_ready_a, all_v ? (1 << M) - 1 : 0);
      check({tag, " s_ready_w"}, s_ready_w, all_v ? (1 << M) - 1 : 0);
      if (all_v) beat++;
      budget++;
      @(negedge clk);
    end
    check({tag, " beats_fed"}, beat, v.k);
    s_valid_a = '0;
    s_valid_w = '0;
    first_mv = -1; done_c = -1; held = 0; nrow = 0; budget = 0;
    while (done_c < 0 && budget < 60) begin
      m_ready = 1'b1;
      if (m_valid) begin
        if (first_mv < 0) first_mv = cyc;
        if (held > 0 && nrow == int'(v.hold_row)) begin
          for (int j = 0; j < M; j++) check({tag, " held_data"}, m_data[j], snap[j]);
          check({tag, " held_row"}, m_row, snap_row);
        end
        if (m_row == v.hold_row && held < int'(v.hold_len)) begin
          if (held == 0) begin
            for (int j = 0; j < M; j++) snap[j] = m_data[j];
            snap_row = m_row;
          end
          m_ready = 1'b0;
          held++;
        end
        if (m_ready) begin
          check({tag, " m_row"}, m_row, nrow);
          check({tag, " m_last"}, m_last, (nrow == M - 1) ? 1 : 0);
          if (nrow < M) for (int j = 0; j < M; j++) got[nrow][j] = m_data[j];
          nrow++;
        end
      end
      if (done) begin
        done_c = cyc;
        check({tag, " busy_at_done"}, busy, 0);
      end
      budget++;
      if (done_c < 0) @(negedge clk);
    end
    check({tag, " rows_out"}, nrow, M);
    check({tag, " first_m_valid_cycle"}, first_mv - t0, int'(v.k) + 2*M + int'(v.gap_len));
    check({tag, " done_cycle"}, done_c - t0,
          int'(v.k) + 3*M + int'(v.gap_len) + int'(v.hold_len));
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        check($sformatf("%s C[%0d][%0d]", tag, i, j), got[i][j], $signed(v.c[i][j]));
`ifdef SYSTOLIC_SAT_EN
    check({tag, " sat_flag"}, sat_flag, v.sat);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit   seen_done;
    vec_t rv;
    reset = 1'b1; start = 1'b0; k_len = '0; m_ready = 1'b1;
    s_valid_a = '1; s_valid_w = '1;
    for (int i = 0; i < M; i++) begin s_data_a[i] = '0; s_data_w[i] = '0; end
    repeat (2) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset s_ready_a", s_ready_a, 0);
    check("reset s_ready_w", s_ready_w, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_last", m_last, 0);
    check("reset m_row", m_row, 0);
    check("reset done", done, 0);
    reset = 1'b0;
    s_valid_a = '0; s_valid_w = '0;
    @(negedge clk);

    for (int t = 0; t < NV; t++) vecs[t] = '0;
    // A = W = [[1,2,3],[4,5,6],[7,8,9]]
    vecs[0].k = 4'd3;
    for (int kk = 0; kk < 3; kk++)
      for (int i = 0; i < M; i++) begin
        vecs[0].a[kk][i] = DW'(3*i + kk + 1);
        vecs[0].w[kk][i] = DW'(3*kk + i + 1);
      end
    set_row(0, 0, 30, 36, 42);
    set_row(0, 1, 66, 81, 96);
    set_row(0, 2, 102, 126, 150);
    vecs[1] = vecs[0]; vecs[1].gap_at = 4'd1;   vecs[1].gap_len  = 4'd2;
    vecs[2] = vecs[0]; vecs[2].hold_row = 2'd1; vecs[2].hold_len = 4'd3;
    // A all ones, W[k][j] = j-2
    vecs[3].k = 4'd5;
    for (int kk = 0; kk < 5; kk++)
      for (int i = 0; i < M; i++) begin
        vecs[3].a[kk][i] = DW'(1);
        vecs[3].w[kk][i] = DW'(i - 2);
      end
    for (int r = 0; r < M; r++) set_row(3, r, -10, -5, 0);
    // identity times identity, run straight after vecs[3]
    vecs[4].k = 4'd3;
    for (int kk = 0; kk < 3; kk++)
      for (int i = 0; i < M; i++) begin
        vecs[4].a[kk][i] = DW'((i == kk) ? 1 : 0);
        vecs[4].w[kk][i] = DW'((i == kk) ? 1 : 0);
      end
    set_row(4, 0, 1, 0, 0);
    set_row(4, 1, 0, 1, 0);
    set_row(4, 2, 0, 0, 1);
    // all operands 32767 for 4 beats: 4*32767^2 overflows 32 bits
    vecs[5].k = 4'd4;
    for (int kk = 0; kk < 4; kk++)
      for (int i = 0; i < M; i++) begin
        vecs[5].a[kk][i] = DW'(32767);
        vecs[5].w[kk][i] = DW'(32767);
      end
`ifdef SYSTOLIC_SAT_EN
    for (int r = 0; r < M; r++) set_row(5, r, 2147483647, 2147483647, 2147483647);
    vecs[5].sat = 1'b1;
`else
    for (int r = 0; r < M; r++) set_row(5, r, -262140, -262140, -262140);
`endif
    // k_len at K_MAX with random operands
    vecs[6].k = 4'(K_MAX);
    for (int kk = 0; kk < K_MAX; kk++)
      for (int i = 0; i < M; i++) begin
        vecs[6].a[kk][i] = DW'($urandom);
        vecs[6].w[kk][i] = DW'($urandom);
      end
    vecs[6] = model(vecs[6]);

    for (int t = 0; t < NV; t++) run_job(vecs[t], $sformatf("vec%0d", t));

    // reset during FLUSH discards the job silently
    start = 1'b1; k_len = KW'(2);
    @(negedge clk);
    start = 1'b0; s_valid_a = '1; s_valid_w = '1;
    repeat (2) @(negedge clk);
    s_valid_a = '0; s_valid_w = '0;
    check("flush busy", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", busy, 0);
    check("midreset m_valid", m_valid, 0);
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (done || busy) seen_done = 1'b1;
      @(negedge clk);
    end
    check("midreset no_done_or_busy", seen_done, 0);
    run_job(vecs[0], "after_reset");

    // illegal k_len values are ignored
    start = 1'b1; k_len = '0;
    @(negedge clk);
    start = 1'b0;
    check("k_len0 ignored", busy, 0);
    start = 1'b1; k_len = KW'(K_MAX + 1);
    @(negedge clk);
    start = 1'b0;
    check("k_len_over ignored", busy, 0);

    for (int n = 0; n < 6; n++) begin
      rv = '0;
      rv.k = 4'($urandom_range(1, K_MAX));
      for (int kk = 0; kk < int'(rv.k); kk++)
        for (int i = 0; i < M; i++) begin
          rv.a[kk][i] = DW'($urandom);
          rv.w[kk][i] = DW'($urandom);
        end
      rv.gap_at   = 4'($urandom_range(0, int'(rv.k) - 1));
      rv.gap_len  = 4'($urandom_range(0, 2));
      rv.hold_row = 2'($urandom_range(0, M - 1));
      rv.hold_len = 4'($urandom_range(0, 2));
      rv = model(rv);
      run_job(rv, $sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
